// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and helpers for the boot-loaded unified memory.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

    localparam int ADDR_W           = 32;
    localparam int DATA_W           = 64;
    localparam int LANES            = DATA_W / 8;
    localparam int DEF_LOAD_LATENCY = 1;

    typedef enum logic [2:0] {
        ST_LEN0 = 3'd0,
        ST_LEN1 = 3'd1,
        ST_LEN2 = 3'd2,
        ST_LEN3 = 3'd3,
        ST_DATA = 3'd4,
        ST_CSUM = 3'd5,
        ST_RUN  = 3'd6,
        ST_ERR  = 3'd7
    } boot_state_t;

    // Big-endian word: byte offset k lives in write-enable lane 7-k.
    function automatic logic [2:0] byte_lane(input logic [2:0] offset);
        return 3'd7 - offset;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_read_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mem_read_pipe
//  Description : LATENCY-stage read data delay line, cleared by reset.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_read_pipe #(
    parameter int LATENCY = 1,
    parameter int WIDTH   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_d [LATENCY];
    logic [WIDTH-1:0] pipe_q [LATENCY];

    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign dout = pipe_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/boot_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : boot_mem_unit
//  Description : Byte-addressed 64-bit unified memory with instruction and
//                data read ports and a byte-stream boot loader. Defining
//                MEM_BOOT_CHECKSUM_EN adds a trailing checksum byte check.
//  Revision    : 1.0  initial release
// ============================================================================
module boot_mem_unit
    import mem_pkg::*;
#(
    parameter int LOAD_LATENCY = DEF_LOAD_LATENCY,
    parameter int DEPTH_W      = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_valid,
    input  logic [7:0]        boot_data,
    output logic              boot_ready,
    output logic              boot_err,
    output logic              core_rst,
    input  logic [ADDR_W-1:0] pc_to_mem,
    output logic [DATA_W-1:0] ld_data_for_inst,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [LANES-1:0]  we,
    output logic [DATA_W-1:0] ld_data
);

    localparam int WORDS = 1 << DEPTH_W;
    localparam int CAP_W = DEPTH_W + 3;

`ifdef MEM_BOOT_CHECKSUM_EN
    localparam boot_state_t ST_AFTER_DATA = ST_CSUM;
`else
    localparam boot_state_t ST_AFTER_DATA = ST_RUN;
`endif

    boot_state_t       state_q, state_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              accept;
    logic              in_range;
    logic [LANES-1:0]  wr_en;
    logic [DEPTH_W-1:0] wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] inst_rd;
    logic [DATA_W-1:0] data_rd;
    logic [DATA_W-1:0] mem [WORDS];

`ifdef MEM_BOOT_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{pc_to_mem[ADDR_W-1:CAP_W], pc_to_mem[2:0],
                                mem_addr[ADDR_W-1:CAP_W], mem_addr[2:0]};

    assign boot_ready = state_q inside {ST_LEN0, ST_LEN1, ST_LEN2, ST_LEN3, ST_DATA, ST_CSUM};
    assign core_rst   = (state_q != ST_RUN);
    assign accept     = boot_valid && boot_ready;
    // Boot bytes past the capacity are consumed but never wrap onto low memory.
    assign in_range   = ((cnt_q >> CAP_W) == '0);

`ifdef MEM_BOOT_CHECKSUM_EN
    assign boot_err = (state_q == ST_ERR);
`else
    assign boot_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
`ifdef MEM_BOOT_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (accept) begin
            case (state_q)
                ST_LEN0: begin
                    len_d[7:0] = boot_data;
                    state_d    = ST_LEN1;
                end
                ST_LEN1: begin
                    len_d[15:8] = boot_data;
                    state_d     = ST_LEN2;
                end
                ST_LEN2: begin
                    len_d[23:16] = boot_data;
                    state_d      = ST_LEN3;
                end
                ST_LEN3: begin
                    len_d[31:24] = boot_data;
                    cnt_d        = '0;
                    state_d      = (len_d == '0) ? ST_AFTER_DATA : ST_DATA;
                end
                ST_DATA: begin
                    cnt_d = cnt_q + 32'd1;
`ifdef MEM_BOOT_CHECKSUM_EN
                    sum_d = sum_q + boot_data;
`endif
                    if (cnt_q == len_q - 32'd1) begin
                        state_d = ST_AFTER_DATA;
                    end
                end
`ifdef MEM_BOOT_CHECKSUM_EN
                ST_CSUM: begin
                    state_d = (boot_data == sum_q) ? ST_RUN : ST_ERR;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LEN0;
            len_q   <= '0;
            cnt_q   <= '0;
`ifdef MEM_BOOT_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
`ifdef MEM_BOOT_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // One write port shared by the loader and the core; they never overlap.
    always_comb begin
        wr_en   = '0;
        wr_idx  = mem_addr[CAP_W-1:3];
        wr_data = st_data;
        if (state_q == ST_RUN) begin
            wr_en = we;
        end else if (accept && (state_q == ST_DATA) && in_range) begin
            wr_en   = LANES'(1) << byte_lane(cnt_q[2:0]);
            wr_idx  = cnt_q[CAP_W-1:3];
            wr_data = {LANES{boot_data}};
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
                mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Combinational array read ahead of the pipes gives read-first behaviour.
    assign inst_rd = mem[pc_to_mem[CAP_W-1:3]];
    assign data_rd = mem[mem_addr[CAP_W-1:3]];

    mem_read_pipe #(
        .LATENCY (LOAD_LATENCY),
        .WIDTH   (DATA_W)
    ) u_inst_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (inst_rd),
        .dout (ld_data_for_inst)
    );

    mem_read_pipe #(
        .LATENCY (LOAD_LATENCY),
        .WIDTH   (DATA_W)
    ) u_data_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (data_rd),
        .dout (ld_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_boot_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boot_mem_unit
//  Description : Self-checking bench; two instances (latency 1 and 3) share
//                stimulus and are scored against a byte-level memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_boot_mem_unit;

    localparam int DEPTH_W = 6;
    localparam int CAP     = 8 << DEPTH_W;
`ifdef MEM_BOOT_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        boot_valid = 1'b0;
    logic [7:0]  boot_data = '0;
    logic [31:0] pc_to_mem = '0;
    logic [31:0] mem_addr = '0;
    logic [63:0] st_data = '0;
    logic [7:0]  we = '0;
    logic        rdy1, err1, crst1, rdy3, err3, crst3;
    logic [63:0] inst1, ld1, inst3, ld3;

    always #5 clk = ~clk;

    boot_mem_unit #(.LOAD_LATENCY(1), .DEPTH_W(DEPTH_W)) u_dut1 (
        .clk(clk), .rst(rst), .boot_valid(boot_valid), .boot_data(boot_data),
        .boot_ready(rdy1), .boot_err(err1), .core_rst(crst1),
        .pc_to_mem(pc_to_mem), .ld_data_for_inst(inst1),
        .mem_addr(mem_addr), .st_data(st_data), .we(we), .ld_data(ld1));

    boot_mem_unit #(.LOAD_LATENCY(3), .DEPTH_W(DEPTH_W)) u_dut3 (
        .clk(clk), .rst(rst), .boot_valid(boot_valid), .boot_data(boot_data),
        .boot_ready(rdy3), .boot_err(err3), .core_rst(crst3),
        .pc_to_mem(pc_to_mem), .ld_data_for_inst(inst3),
        .mem_addr(mem_addr), .st_data(st_data), .we(we), .ld_data(ld3));

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [63:0] m; logic [63:0] d; } rd_t;

    byte unsigned mm [CAP];
    bit           mk [CAP];
    longint       m_cnt = 0;
    logic [31:0]  m_len = '0;
    logic [7:0]   m_sum = '0;
    bit           m_err = 1'b0;
    rd_t          q1i[$], q1d[$], q3i[$], q3d[$];

    function automatic bit m_run();
        return !m_err && (m_cnt >= 4) && (m_cnt == 4 + longint'(m_len) + CS);
    endfunction

    function automatic bit m_ready();
        return !m_err && !m_run();
    endfunction

    function automatic rd_t rd_word(input logic [31:0] addr);
        rd_t r = '0;
        int unsigned base = (addr % CAP) / 8 * 8;
        for (int k = 0; k < 8; k++) begin
            if (mk[base+k]) begin
                r.d[63-8*k -: 8] = mm[base+k];
                r.m[63-8*k -: 8] = 8'hFF;
            end
        end
        return r;
    endfunction

    task automatic m_accept(input logic [7:0] b);
        if (m_cnt < 4) begin
            m_len[8*int'(m_cnt) +: 8] = b;
        end else if (m_cnt < 4 + longint'(m_len)) begin
            longint a = m_cnt - 4;
            if (a < CAP) begin
                mm[int'(a)] = b;
                mk[int'(a)] = 1'b1;
            end
            m_sum = m_sum + b;
        end else if (b != m_sum) begin
            m_err = 1'b1;
        end
        m_cnt++;
    endtask

    task automatic m_core_write();
        int unsigned base = (mem_addr % CAP) / 8 * 8;
        for (int i = 0; i < 8; i++) begin
            if (we[i]) begin
                mm[base+7-i] = st_data[8*i +: 8];
                mk[base+7-i] = 1'b1;
            end
        end
    endtask

    task automatic mdl_reset();
        m_cnt = 0; m_len = '0; m_sum = '0; m_err = 1'b0;
        q1i.delete(); q1d.delete(); q3i.delete(); q3d.delete();
        q1i.push_back('0); q1d.push_back('0);
        for (int i = 0; i < 3; i++) begin
            q3i.push_back('0); q3d.push_back('0);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_reset();
        end else begin
            rd_t ri, rdd;
            ri  = rd_word(pc_to_mem);
            rdd = rd_word(mem_addr);
            q1i.push_back(ri);  void'(q1i.pop_front());
            q1d.push_back(rdd); void'(q1d.pop_front());
            q3i.push_back(ri);  void'(q3i.pop_front());
            q3d.push_back(rdd); void'(q3d.pop_front());
            if (boot_valid && m_ready()) m_accept(boot_data);
            else if (m_run()) m_core_write();
        end
    end

    task automatic check_rd(input string tag, input logic [63:0] obs, input rd_t e);
        if (e.m != '0) check(tag, obs & e.m, e.d);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready_L1", rdy1, m_ready());
            check("ready_L3", rdy3, m_ready());
            check("core_rst_L1", crst1, !m_run());
            check("core_rst_L3", crst3, !m_run());
            check("boot_err_L1", err1, m_err);
            check("boot_err_L3", err3, m_err);
            check_rd("inst_L1", inst1, q1i[0]);
            check_rd("data_L1", ld1, q1d[0]);
            check_rd("inst_L3", inst3, q3i[0]);
            check_rd("data_L3", ld3, q3d[0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_core();
        pc_to_mem = $urandom_range(0, 2*CAP-1);
        mem_addr  = $urandom_range(0, 2*CAP-1);
        st_data   = {$urandom, $urandom};
        we        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
            boot_valid = 1'b0;
            boot_data  = 8'($urandom);
            rand_core();
            tick();
        end
        boot_valid = 1'b1;
        boot_data  = b;
        rand_core();
        tick();
        boot_valid = 1'b0;
        we         = '0;
    endtask

    task automatic send_len(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
    endtask

    task automatic boot_image(input logic [7:0] img[$]);
        logic [7:0] s = '0;
        send_len(img.size());
        foreach (img[i]) begin
            send_byte(img[i]);
            s = s + img[i];
        end
`ifdef MEM_BOOT_CHECKSUM_EN
        send_byte(s);
`endif
    endtask

    task automatic apply_reset();
        #2 rst = 1'b1;
        #1;
        check("async_core_rst_L1", crst1, 1'b1);
        check("async_core_rst_L3", crst3, 1'b1);
        check("async_ready_L1", rdy1, 1'b1);
        check("async_ld_L3", ld3, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    localparam logic [63:0] W0_OLD = 64'h1122_3344_0000_0000;
    localparam logic [63:0] W0_NEW = 64'h1122_3344_0000_00AB;

    initial begin
        logic [7:0] img[$];
        #1 rst = 1'b1;
        #1;
        check("rst_core_rst", crst1, 1'b1);
        check("rst_ready", rdy3, 1'b1);
        check("rst_err", err1, 1'b0);
        check("rst_ld_L1", ld1, 64'h0);
        check("rst_inst_L3", inst3, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Full image that overruns capacity by one word; bytes 4..7 left zero.
        img.delete();
        for (int a = 0; a < CAP + 8; a++) img.push_back((a >= 4 && a < 8) ? 8'h00 : 8'($urandom));
        boot_image(img);
        check("bootA_core_rst", crst1, 1'b0);
        tick();
        tick();

        apply_reset();

        send_len(32'd4);
        send_byte(8'h11);
        send_byte(8'h22);
        apply_reset();

        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        boot_image(img);
        check("bootC_core_rst", crst3, 1'b0);
        pc_to_mem = 32'd0;
        mem_addr  = 32'd0;
        we        = '0;
        repeat (3) tick();
        check("fetch0_L1", inst1, W0_OLD);
        check("fetch0_L3", inst3, W0_OLD);
        pc_to_mem = 32'd3;
        repeat (3) tick();
        check("fetch3_L1", inst1, W0_OLD);
        check("fetch3_L3", inst3, W0_OLD);

        mem_addr = 32'd7;
        we       = 8'h01;
        st_data  = 64'hAB;
        tick();
        we = '0;
        check("rf_old_L1", ld1, W0_OLD);
        tick();
        check("rf_new_L1", ld1, W0_NEW);
        tick();
        check("rf_old_L3", ld3, W0_OLD);
        tick();
        check("rf_new_L3", ld3, W0_NEW);

        for (int c = 0; c < 300; c++) begin
            rand_core();
            boot_valid = 1'($urandom);
            boot_data  = 8'($urandom);
            tick();
        end
        boot_valid = 1'b0;
        we         = '0;

        apply_reset();
        send_len(32'd0);
`ifdef MEM_BOOT_CHECKSUM_EN
        check("n0_wait_csum", crst1, 1'b1);
        send_byte(8'h00);
`endif
        check("n0_core_rst_L1", crst1, 1'b0);
        check("n0_core_rst_L3", crst3, 1'b0);
        tick();

`ifdef MEM_BOOT_CHECKSUM_EN
        apply_reset();
        send_len(32'd2);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h31);
        tick();
        check("bad_csum_err", err1, 1'b1);
        check("bad_csum_core_rst", crst3, 1'b1);
        check("bad_csum_ready", rdy1, 1'b0);
        apply_reset();
        send_len(32'd2);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        check("good_csum_core_rst", crst1, 1'b0);
        check("good_csum_err", err3, 1'b0);
        tick();
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
